// File: rtl/mips_pkg.sv
// Shared constants and the store-buffer entry record for the MIPS core.
package mips_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 16;
    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_entry_file.sv
// Store-buffer entry storage with a youngest-first address match for load forwarding.
module sb_entry_file
    import mips_pkg::*;
#(
    parameter int DEPTH = mips_pkg::SB_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [PW-1:0]             wr_idx,
    input  logic [mips_pkg::ADDR_W-1:0] wr_addr,
    input  logic [mips_pkg::DATA_W-1:0] wr_data,
    input  logic                      clr_en,
    input  logic [PW-1:0]             clr_idx,
    input  logic [PW-1:0]             head,
    input  logic [mips_pkg::ADDR_W-1:0] ld_addr,
    output logic                      hit,
    output logic [mips_pkg::DATA_W-1:0] hit_data,
    output logic [mips_pkg::ADDR_W-1:0] head_addr,
    output logic [mips_pkg::DATA_W-1:0] head_data
);

    sb_entry_t       entry_r [DEPTH];
    logic [PW-1:0]   idx_s;
    logic            match_s;

    // Entry storage; a write to the slot being retired in the same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '0;
            end
        end else begin
            if (clr_en) begin
                entry_r[clr_idx].valid <= 1'b0;
            end
            if (wr_en) begin
                entry_r[wr_idx] <= '{valid: 1'b1, addr: wr_addr, data: wr_data};
            end
        end
    end

    // Walk oldest to youngest from head so the last match seen is the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx_s    = '0;
        match_s  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s    = head + PW'(i);
            match_s  = entry_r[idx_s].valid && (entry_r[idx_s].addr == ld_addr);
            hit      = hit | match_s;
            hit_data = match_s ? entry_r[idx_s].data : hit_data;
        end
    end

    assign head_addr = entry_r[head].addr;
    assign head_data = entry_r[head].data;

endmodule

// File: rtl/store_buffer.sv
// Store buffer between MEM stage and data memory: FIFO control, load forwarding, memory-port mux.
module store_buffer
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int DEPTH  = mips_pkg::SB_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              stall,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_data_valid,
    output logic              sb_empty,
    output logic              d_mem_write_en,
    output logic              d_mem_read,
    output logic [ADDR_W-1:0] d_mem_addr,
    output logic [DATA_W-1:0] d_mem_write_data,
    input  logic [DATA_W-1:0] d_mem_read_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]     head_r, tail_r;
    logic [CW-1:0]     count_r;
    logic [DATA_W-1:0] ld_data_r;
    logic              ld_data_valid_r;

    logic              ld_go_s, drain_s, full_s, stall_s, enq_s, st_fwd_s, hit_s, rd_s;
    logic [DATA_W-1:0] hit_data_s, head_data_s;
    logic [ADDR_W-1:0] head_addr_s;

    // Requests are masked while in reset so the memory port stays quiet.
    assign ld_go_s  = ld_valid && rst_n;
    assign drain_s  = (count_r != '0) && !ld_go_s;
    assign full_s   = (count_r == CW'(DEPTH));
    assign stall_s  = st_valid && rst_n && full_s && !drain_s;
    assign enq_s    = st_valid && rst_n && !stall_s;
    assign st_fwd_s = ld_go_s && enq_s && (st_addr == ld_addr);
    assign rd_s     = ld_go_s && !st_fwd_s && !hit_s;

    sb_entry_file #(
        .DEPTH (DEPTH)
    ) u_entries (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (enq_s),
        .wr_idx    (tail_r),
        .wr_addr   (st_addr),
        .wr_data   (st_data),
        .clr_en    (drain_s),
        .clr_idx   (head_r),
        .head      (head_r),
        .ld_addr   (ld_addr),
        .hit       (hit_s),
        .hit_data  (hit_data_s),
        .head_addr (head_addr_s),
        .head_data (head_data_s)
    );

    // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (drain_s) begin
                head_r <= head_r + PW'(1);
            end
            if (enq_s) begin
                tail_r <= tail_r + PW'(1);
            end
            count_r <= count_r + CW'(enq_s) - CW'(drain_s);
        end
    end

    // Load result register; the same-cycle store is youngest, then the buffer, then memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_data_r       <= '0;
            ld_data_valid_r <= 1'b0;
        end else begin
            ld_data_valid_r <= ld_go_s;
            if (ld_go_s) begin
                ld_data_r <= st_fwd_s ? st_data : (hit_s ? hit_data_s : d_mem_read_data);
            end
        end
    end

    // Memory-port mux: drain, else missed load, else idle zeros.
    always_comb begin
        d_mem_addr       = '0;
        d_mem_write_data = '0;
        if (drain_s) begin
            d_mem_addr       = head_addr_s;
            d_mem_write_data = head_data_s;
        end else if (rd_s) begin
            d_mem_addr       = ld_addr;
        end else begin
            d_mem_addr       = '0;
        end
    end

    assign d_mem_write_en = drain_s;
    assign d_mem_read     = rd_s;
    assign stall          = stall_s;
    assign sb_empty       = (count_r == '0);
    assign ld_data        = ld_data_r;
    assign ld_data_valid  = ld_data_valid_r;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, corner sequences and a queue-based random model.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0, ld_valid = 1'b0;
    logic [15:0] st_addr = 16'h0, st_data = 16'h0, ld_addr = 16'h0;
    logic        stall, ld_data_valid, sb_empty, d_mem_write_en, d_mem_read;
    logic [15:0] ld_data, d_mem_addr, d_mem_write_data, d_mem_read_data;

    logic        mem_clr = 1'b1;
    logic [15:0] ram [256];
    int          wr_count;

    store_buffer dut (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .stall(stall), .ld_data(ld_data),
        .ld_data_valid(ld_data_valid), .sb_empty(sb_empty), .d_mem_write_en(d_mem_write_en),
        .d_mem_read(d_mem_read), .d_mem_addr(d_mem_addr), .d_mem_write_data(d_mem_write_data),
        .d_mem_read_data(d_mem_read_data)
    );

    always #5 clk = ~clk;

    // Data memory: preset to RAM[i]=i, written by the buffer's drains.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'(i);
            wr_count <= 0;
        end else if (d_mem_write_en) begin
            ram[d_mem_addr[7:0]] <= d_mem_write_data;
            wr_count <= wr_count + 1;
        end
    end
    assign d_mem_read_data = ram[d_mem_addr[7:0]];

    typedef struct { logic [15:0] addr; logic [15:0] data; } st_t;
    typedef struct {
        logic sv; logic [15:0] sa, sd; logic lv; logic [15:0] la;
        logic e_stall, e_empty, e_wen, e_rd; logic [15:0] e_addr, e_wdata;
        logic e_ldv; logic [15:0] e_ld;
    } vec_t;

    st_t         q [$];
    logic [15:0] ref_mem [256];
    logic [15:0] last_ld;
    int          n_cmp = 0, n_err = 0;
    vec_t        tab [18];
    vec_t        nov;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                                input logic lv, input logic [15:0] la, input logic es,
                                input logic ee, input logic ew, input logic er,
                                input logic [15:0] ea, input logic [15:0] ed,
                                input logic elv, input logic [15:0] eld);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la;
        v.e_stall = es; v.e_empty = ee; v.e_wen = ew; v.e_rd = er;
        v.e_addr = ea; v.e_wdata = ed; v.e_ldv = elv; v.e_ld = eld;
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        last_ld = 16'h0;
    endtask

    // One cycle: drive at negedge, check the memory port against the model, then the load result.
    task automatic step(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                        input logic lv, input logic [15:0] la, input bit use_tab, input vec_t v);
        bit e_drain, e_stall, e_acc, e_rd, found;
        logic [15:0] e_addr, e_wdata, e_ld;
        st_t ent;
        @(negedge clk);
        st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la;
        #1;
        e_drain = (q.size() > 0) && !lv;
        e_stall = sv && (q.size() == DEPTH) && !e_drain;
        e_acc   = sv && !e_stall;
        e_rd    = 1'b0;
        e_ld    = last_ld;
        found   = 1'b0;
        if (lv) begin
            if (e_acc && sa == la) begin
                e_ld = sd;
            end else begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (!found && q[i].addr == la) begin
                        e_ld = q[i].data;
                        found = 1'b1;
                    end
                end
                if (!found) begin
                    e_rd = 1'b1;
                    e_ld = ref_mem[la[7:0]];
                end
            end
        end
        e_addr  = e_drain ? q[0].addr : (e_rd ? la : 16'h0);
        e_wdata = e_drain ? q[0].data : 16'h0;
        chk("stall", {31'b0, stall}, {31'b0, e_stall});
        chk("sb_empty", {31'b0, sb_empty}, {31'b0, q.size() == 0});
        chk("d_mem_write_en", {31'b0, d_mem_write_en}, {31'b0, e_drain});
        chk("d_mem_read", {31'b0, d_mem_read}, {31'b0, e_rd});
        chk("d_mem_addr", {16'b0, d_mem_addr}, {16'b0, e_addr});
        chk("d_mem_write_data", {16'b0, d_mem_write_data}, {16'b0, e_wdata});
        if (use_tab) begin
            chk("tab_stall", {31'b0, stall}, {31'b0, v.e_stall});
            chk("tab_sb_empty", {31'b0, sb_empty}, {31'b0, v.e_empty});
            chk("tab_write_en", {31'b0, d_mem_write_en}, {31'b0, v.e_wen});
            chk("tab_read", {31'b0, d_mem_read}, {31'b0, v.e_rd});
            chk("tab_addr", {16'b0, d_mem_addr}, {16'b0, v.e_addr});
            chk("tab_wdata", {16'b0, d_mem_write_data}, {16'b0, v.e_wdata});
        end
        @(posedge clk);
        if (e_drain) begin
            ref_mem[q[0].addr[7:0]] = q[0].data;
            void'(q.pop_front());
        end
        if (e_acc) begin
            ent.addr = sa;
            ent.data = sd;
            q.push_back(ent);
        end
        last_ld = e_ld;
        #1;
        chk("ld_data_valid", {31'b0, ld_data_valid}, {31'b0, lv});
        chk("ld_data", {16'b0, ld_data}, {16'b0, last_ld});
        if (use_tab) begin
            chk("tab_ld_valid", {31'b0, ld_data_valid}, {31'b0, v.e_ldv});
            chk("tab_ld_data", {16'b0, ld_data}, {16'b0, v.e_ld});
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_stall"}, {31'b0, stall}, 32'h0);
        chk({tag, "_sb_empty"}, {31'b0, sb_empty}, 32'h1);
        chk({tag, "_write_en"}, {31'b0, d_mem_write_en}, 32'h0);
        chk({tag, "_read"}, {31'b0, d_mem_read}, 32'h0);
        chk({tag, "_addr"}, {16'b0, d_mem_addr}, 32'h0);
        chk({tag, "_wdata"}, {16'b0, d_mem_write_data}, 32'h0);
        chk({tag, "_ld_valid"}, {31'b0, ld_data_valid}, 32'h0);
        chk({tag, "_ld_data"}, {16'b0, ld_data}, 32'h0);
    endtask

    initial begin
        int wr_before;
        nov = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i);
        model_reset();

        //         sv st_a   st_d      lv ld_a  stl emp wen rd  addr   wdata     ldv ld
        tab[0]  = mk(1, 16'h7, 16'h00AA, 0, 16'h0, 0, 1, 0, 0, 16'h0, 16'h0,    0, 16'h0);
        tab[1]  = mk(0, 16'h0, 16'h0,    0, 16'h0, 0, 0, 1, 0, 16'h7, 16'h00AA, 0, 16'h0);
        tab[2]  = mk(0, 16'h0, 16'h0,    0, 16'h0, 0, 1, 0, 0, 16'h0, 16'h0,    0, 16'h0);
        tab[3]  = mk(1, 16'h5, 16'h1111, 1, 16'h9, 0, 1, 0, 1, 16'h9, 16'h0,    1, 16'h9);
        tab[4]  = mk(1, 16'h5, 16'h2222, 1, 16'h9, 0, 0, 0, 1, 16'h9, 16'h0,    1, 16'h9);
        tab[5]  = mk(0, 16'h0, 16'h0,    1, 16'h5, 0, 0, 0, 0, 16'h0, 16'h0,    1, 16'h2222);
        tab[6]  = mk(1, 16'h5, 16'h3333, 1, 16'h5, 0, 0, 0, 0, 16'h0, 16'h0,    1, 16'h3333);
        tab[7]  = mk(1, 16'h6, 16'h4444, 1, 16'h8, 0, 0, 0, 1, 16'h8, 16'h0,    1, 16'h8);
        tab[8]  = mk(1, 16'h6, 16'h5555, 1, 16'h8, 1, 0, 0, 1, 16'h8, 16'h0,    1, 16'h8);
        tab[9]  = mk(1, 16'h6, 16'h5555, 0, 16'h0, 0, 0, 1, 0, 16'h5, 16'h1111, 0, 16'h8);
        tab[10] = mk(0, 16'h0, 16'h0,    1, 16'h6, 0, 0, 0, 0, 16'h0, 16'h0,    1, 16'h5555);
        tab[11] = mk(0, 16'h0, 16'h0,    0, 16'h0, 0, 0, 1, 0, 16'h5, 16'h2222, 0, 16'h5555);
        tab[12] = mk(0, 16'h0, 16'h0,    0, 16'h0, 0, 0, 1, 0, 16'h5, 16'h3333, 0, 16'h5555);
        tab[13] = mk(0, 16'h0, 16'h0,    0, 16'h0, 0, 0, 1, 0, 16'h6, 16'h4444, 0, 16'h5555);
        tab[14] = mk(0, 16'h0, 16'h0,    0, 16'h0, 0, 0, 1, 0, 16'h6, 16'h5555, 0, 16'h5555);
        tab[15] = mk(0, 16'h0, 16'h0,    0, 16'h0, 0, 1, 0, 0, 16'h0, 16'h0,    0, 16'h5555);
        tab[16] = mk(0, 16'h0, 16'h0,    1, 16'h3, 0, 1, 0, 1, 16'h3, 16'h0,    1, 16'h3);
        tab[17] = mk(0, 16'h0, 16'h0,    1, 16'h5, 0, 1, 0, 1, 16'h5, 16'h0,    1, 16'h3333);

        // Reset with requests pending on the inputs: everything must stay quiet.
        st_valid = 1'b1; st_addr = 16'h3; st_data = 16'hBEEF; ld_valid = 1'b1; ld_addr = 16'h3;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        @(negedge clk);
        mem_clr = 1'b0;
        st_valid = 1'b0; ld_valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(tab[i].sv, tab[i].sa, tab[i].sd, tab[i].lv, tab[i].la, 1'b1, tab[i]);
        end

        // Six back-to-back store/drain cycles walk the pointers past the wrap point.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 16'h20 + 16'(i), 16'hA000 + 16'(i), 1'b0, 16'h0, 1'b0, nov);
        end
        step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, nov);
        step(1'b0, 16'h0, 16'h0, 1'b1, 16'h25, 1'b0, nov);
        chk("wrap_last_write", {16'b0, ld_data}, 32'hA005);

        // Three pending stores then an asynchronous reset pulse in mid-cycle.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h40 + 16'(i), 16'hC000 + 16'(i), 1'b1, 16'h50, 1'b0, nov);
        end
        wr_before = wr_count;
        st_valid = 1'b1; st_addr = 16'h41; ld_valid = 1'b1; ld_addr = 16'h40;
        rst_n = 1'b0;
        #1;
        chk_quiet("midreset");
        #2;
        rst_n = 1'b1;
        st_valid = 1'b0; ld_valid = 1'b0;
        model_reset();
        repeat (3) step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, nov);
        chk("midreset_no_writes", wr_count, wr_before);
        step(1'b0, 16'h0, 16'h0, 1'b1, 16'h41, 1'b0, nov);

        // Random traffic over a small address range to provoke hits, fills and stalls.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 16'($urandom),
                 1'($urandom_range(0, 9) < 5), 16'($urandom_range(0, 7)), 1'b0, nov);
        end
        while (q.size() > 0) step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, nov);
        for (int a = 0; a < 8; a++) begin
            chk("final_mem", {16'b0, ram[a]}, {16'b0, ref_mem[a]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, word-address width.
REQ-003 SHALL have parameter DEPTH, default 4, entry count; a power of two.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port st_valid  input  1  store request from the MEM stage.
REQ-007 SHALL have port st_addr  input  ADDR_W  store address.
REQ-008 SHALL have port st_data  input  DATA_W  store data.
REQ-009 SHALL have port ld_valid  input  1  load request from the MEM stage.
REQ-010 SHALL have port ld_addr  input  ADDR_W  load address.
REQ-011 SHALL have port stall  output  1  store not accepted this cycle; the MEM stage holds its request.
REQ-012 SHALL have port ld_data  output  DATA_W  load result, registered.
REQ-013 SHALL have port ld_data_valid  output  1  ld_data is valid, one cycle after ld_valid.
REQ-014 SHALL have port sb_empty  output  1  no pending stores; used for fences and halt.
REQ-015 SHALL have port d_mem_write_en  output  1  write strobe to data_memory.
REQ-016 SHALL have port d_mem_read  output  1  read strobe to data_memory.
REQ-017 SHALL have port d_mem_addr  output  ADDR_W  address to data_memory.
REQ-018 SHALL have port d_mem_write_data  output  DATA_W  write data to data_memory.
REQ-019 SHALL have port d_mem_read_data  input  DATA_W  combinational read data from data_memory, valid in the same cycle as d_mem_read.

Function
REQ-020 SHALL hold stores in a circular FIFO of DEPTH entries, with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH and a count of 0..DEPTH.
REQ-021 SHALL perform a drain in any cycle with count>0 and ld_valid=0: d_mem_write_en=1, d_mem_addr and d_mem_write_data from the head entry, head advances at the edge.
REQ-022 SHALL give a load priority over a drain: with ld_valid=1 there is no drain, and the d_mem_* outputs carry the read or are idle.
REQ-023 SHALL enqueue a store at the tail when st_valid=1 and stall=0.
REQ-024 SHALL set stall = st_valid AND count==DEPTH AND no drain this cycle; a full buffer that drains in the same cycle accepts the store, and count is unchanged.
REQ-025 SHALL forward on a load whose ld_addr matches one or more valid entries: the youngest matching entry supplies the data, with d_mem_read=0.
REQ-026 SHALL treat a store accepted in the same cycle as a load as older than that load, so a same-address pair forwards st_data.
REQ-027 SHALL, on a load with no match, drive d_mem_read=1 and d_mem_addr=ld_addr, and capture d_mem_read_data.
REQ-028 SHALL assert ld_data_valid for exactly one cycle at the edge after ld_valid, with ld_data held until the next load.
REQ-029 SHALL drive d_mem_write_en and d_mem_read mutually exclusively; both are 0 when idle, and d_mem_addr and d_mem_write_data are 0 when idle.
REQ-030 SHALL assert sb_empty combinationally whenever count==0.
REQ-031 SHALL ignore st_addr and st_data when st_valid=0.
REQ-032 SHALL ignore ld_addr when ld_valid=0.

Reset
REQ-033 SHALL, on rst_n=0 and asynchronously, clear head, tail, count, all entry valid bits, ld_data and ld_data_valid to 0.
REQ-034 SHALL hold outputs during reset at stall=0, sb_empty=1, and all d_mem_* outputs at 0.
REQ-035 SHALL discard pending stores on reset mid-operation with no memory write, and lose an in-flight load result.
REQ-036 SHALL accept requests from the first rising edge after rst_n deasserts.

Structure
REQ-037 SHALL take DATA_W, ADDR_W and SB_DEPTH constants, and the entry record typedef (valid, addr, data), from the shared package mips_pkg.
REQ-038 SHALL place entry storage and the youngest-match search in one sub-module, sb_entry_file; FIFO control and the memory-port mux stay in store_buffer.

Verification
REQ-039 SHALL cover: store 0x00AA to addr 7, then idle -> the next cycle shows d_mem_write_en=1, addr 7, data 0x00AA, then sb_empty=1.
REQ-040 SHALL cover: stores 0x1111 then 0x2222 to addr 5, followed at once by a load of addr 5 -> ld_data=0x2222 one cycle later, d_mem_read=0.
REQ-041 SHALL cover: 4 stores while loads block drains, then a 5th store with a load -> stall=1; drop the load -> stall=0, drain and enqueue happen together, and count stays 4.
REQ-042 SHALL cover: a load of addr 3 with the buffer empty and RAM[3]=3 -> d_mem_read=1 and d_mem_addr=3 that cycle, ld_data=3 with ld_data_valid=1 next cycle.
REQ-043 SHALL cover: 6 store/drain cycles so the pointers wrap -> memory writes occur in FIFO order, with no loss or duplication.
REQ-044 SHALL cover: 3 pending stores, rst_n pulsed low mid-cycle -> outputs go to 0 immediately, sb_empty=1, and no further memory writes occur.
